// File: rtl/andor_sweep_ctrl.sv
// Self-test sequencer for a two-input AndOr gate unit: sweeps {a,b} through
// all four patterns LOOPS times and checks the and/or/not outputs after a settle time.
module andor_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic       dut_a,
   output logic       dut_b,
   input  logic       dut_and,
   input  logic       dut_or,
   input  logic       dut_not,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_vec,
   output logic [7:0] fail_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_pattern;
   logic [7:0] r_loop;
   logic [3:0] r_settle;
   logic       r_dut_a;
   logic       r_dut_b;
   logic       r_pass;
   logic [3:0] r_err_vec;
   logic [7:0] r_fail_cnt;
   logic       w_abort;
   logic       w_mismatch;

   // abort only matters once a run is in flight
   assign w_abort    = abort && (r_state != S_IDLE);
   assign w_mismatch = (dut_and != (r_dut_a & r_dut_b)) ||
                       (dut_or  != (r_dut_a | r_dut_b)) ||
                       (dut_not != ~r_dut_a);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: next-state defaults to hold before the case, so no path infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_DRIVE;
         S_DRIVE:  w_next = S_SETTLE;
         S_SETTLE: if (r_settle <= 4'd1) w_next = S_CHECK;
         S_CHECK: begin
            if (r_pattern != 2'd3)       w_next = S_DRIVE;
            else if (r_loop < LAST_LOOP) w_next = S_DRIVE;
            else                         w_next = S_DONE;
         end
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern  <= 2'd0;
         r_loop     <= 8'd0;
         r_settle   <= 4'd0;
         r_dut_a    <= 1'b0;
         r_dut_b    <= 1'b0;
         r_pass     <= 1'b0;
         r_err_vec  <= 4'd0;
         r_fail_cnt <= 8'd0;
      end else if (w_abort) begin
         r_dut_a <= 1'b0;
         r_dut_b <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pattern  <= 2'd0;
                  r_loop     <= 8'd0;
                  r_pass     <= 1'b0;
                  r_err_vec  <= 4'd0;
                  r_fail_cnt <= 8'd0;
               end
            end
            S_DRIVE: begin
               {r_dut_a, r_dut_b} <= r_pattern;
               r_settle           <= SETTLE_LOAD;
            end
            S_SETTLE: r_settle <= r_settle - 4'd1;
            S_CHECK: begin
               if (w_mismatch) begin
                  r_err_vec[r_pattern] <= 1'b1;
                  if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
               end
               if (r_pattern == 2'd3) r_loop <= r_loop + 8'd1;
               r_pattern <= r_pattern + 2'd1;
            end
            // err_vec already includes any bit set by the final check
            S_DONE:  r_pass <= (r_err_vec == 4'd0);
            default: ;
         endcase
      end
   end

   assign dut_a    = r_dut_a;
   assign dut_b    = r_dut_b;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign pass     = r_pass;
   assign err_vec  = r_err_vec;
   assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_andor_sweep_ctrl.sv
// Directed bench: four sequencer instances, each against a gate model with a
// different (or no) planted gate fault and a different parameter set.
`timescale 1ns/1ps
module tb_andor_sweep_ctrl;

   localparam int N = 4;
   localparam int SET_P  [N] = '{2, 2, 1, 2};
   localparam int LOOP_P [N] = '{1, 3, 1, 255};
   // 0: correct gate, 1: or stuck at 0, 2: not wired to b, 3: all outputs stuck at 1
   localparam int FLT_P  [N] = '{0, 1, 2, 3};

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] start_v;
   logic [N-1:0] abort_v;
   wire  [N-1:0] a_v, b_v, busy_v, done_v, pass_v;
   wire  [N-1:0][3:0] err_v;
   wire  [N-1:0][7:0] cnt_v;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_unit
      localparam int FLT = FLT_P[g];
      logic w_and, w_or, w_not;
      always_comb begin
         w_and = a_v[g] & b_v[g];
         w_or  = a_v[g] | b_v[g];
         w_not = ~a_v[g];
         if (FLT == 1) w_or = 1'b0;
         if (FLT == 2) w_not = b_v[g];
         if (FLT == 3) begin
            w_and = 1'b1;
            w_or  = 1'b1;
            w_not = 1'b1;
         end
      end
      andor_sweep_ctrl #(.SETTLE_CYCLES(SET_P[g]), .LOOPS(LOOP_P[g])) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start_v[g]),
         .abort    (abort_v[g]),
         .dut_a    (a_v[g]),
         .dut_b    (b_v[g]),
         .dut_and  (w_and),
         .dut_or   (w_or),
         .dut_not  (w_not),
         .busy     (busy_v[g]),
         .done     (done_v[g]),
         .pass     (pass_v[g]),
         .err_vec  (err_v[g]),
         .fail_cnt (cnt_v[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // start sampled at the next edge (edge 0); returns in cycle 1 (DRIVE)
   task automatic pulse_start(input int i);
      start_v[i] = 1'b1;
      tick();
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int limit, output int n);
      n = 0;
      while (!done_v[i] && n < limit) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [31:0] snap(input int i);
      return {busy_v[i], done_v[i], pass_v[i], a_v[i], b_v[i], err_v[i], cnt_v[i]};
   endfunction

   initial begin
      int n;
      int seen;
      rst     = 1'b1;
      start_v = '0;
      abort_v = '0;
      repeat (3) tick();
      rst = 1'b0;

      for (int i = 0; i < N; i++) check("reset_values", snap(i), 32'd0);

      // defaults, correct gate; start re-pulsed mid-run must be ignored
      pulse_start(0);
      for (int c = 1; c <= 17; c++) begin
         check("run_busy", busy_v[0], 1);
         check("run_done", done_v[0], (c == 17) ? 1 : 0);
         check("run_drive", {a_v[0], b_v[0]}, (c < 2) ? 0 : (c - 2) / 4);
         if (c == 6) start_v[0] = 1'b1;
         if (c < 17) tick();
         start_v[0] = 1'b0;
      end
      tick();
      check("idle_busy", busy_v[0], 0);
      check("idle_done", done_v[0], 0);
      check("clean_pass", pass_v[0], 1);
      check("clean_err", err_v[0], 4'b0000);
      check("clean_cnt", cnt_v[0], 8'd0);

      // back-to-back run from the first idle cycle
      pulse_start(0);
      check("b2b_busy", busy_v[0], 1);
      check("b2b_pass_cleared", pass_v[0], 0);
      wait_done(0, 100, n);
      check("b2b_latency", n, 16);
      tick();
      check("b2b_pass", pass_v[0], 1);
      check("b2b_busy_fall", busy_v[0], 0);

      // or stuck at 0, LOOPS=3: patterns 1,2,3 fail each loop
      pulse_start(1);
      wait_done(1, 200, n);
      check("orstuck_latency", n, 48);
      check("orstuck_err", err_v[1], 4'b1110);
      check("orstuck_cnt", cnt_v[1], 8'd9);
      tick();
      check("orstuck_pass", pass_v[1], 0);
      check("orstuck_busy", busy_v[1], 0);

      // not wired to b, SETTLE_CYCLES=1: patterns 0 and 3 fail
      pulse_start(2);
      wait_done(2, 100, n);
      check("notb_latency", n, 12);
      check("notb_err", err_v[2], 4'b1001);
      check("notb_cnt", cnt_v[2], 8'd2);
      tick();
      check("notb_pass", pass_v[2], 0);

      // all outputs stuck at 1, LOOPS=255: 1020 failing checks saturate
      pulse_start(3);
      wait_done(3, 5000, n);
      check("sat_latency", n, 4080);
      check("sat_cnt", cnt_v[3], 8'd255);
      check("sat_err", err_v[3], 4'b1111);
      tick();
      check("sat_pass", pass_v[3], 0);

      // abort during SETTLE of pattern 2
      pulse_start(0);
      repeat (9) tick();
      check("abort_pre_drive", {a_v[0], b_v[0]}, 2'b10);
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      check("abort_busy", busy_v[0], 0);
      check("abort_done", done_v[0], 0);
      check("abort_drive", {a_v[0], b_v[0]}, 2'b00);
      check("abort_pass", pass_v[0], 0);
      seen = 0;
      repeat (20) begin
         tick();
         if (done_v[0] || busy_v[0]) seen++;
      end
      check("abort_quiet", seen, 0);

      // start and abort together in IDLE: start wins, then a clean sweep
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      check("start_wins", busy_v[0], 1);
      wait_done(0, 100, n);
      check("rerun_latency", n, 16);
      tick();
      check("rerun_pass", pass_v[0], 1);
      check("rerun_err", err_v[0], 4'b0000);

      // rst during CHECK of pattern 1 on the failing unit
      pulse_start(3);
      repeat (7) tick();
      check("pre_rst_cnt", cnt_v[3], 8'd1);
      check("pre_rst_err", err_v[3], 4'b0001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_values", snap(3), 32'd0);
      check("rst_other_pass", pass_v[0], 0);
      tick();
      check("rst_stays_idle", busy_v[3], 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
